noc_packetizer: RTL and testbench

Store-and-forward packet builder on the injection side of the NoC: takes a local AXI-Stream payload and emits router packets (one header flit followed by payload flits) into a router input channel. Payload beats are buffered until source TLAST or until the per-packet payload limit is reached. A header carrying destination, source and flit count is then sent, followed by the buffered beats. Sits between an endpoint (PMU or AXI bridge) and one `in[i]` channel of `router_dual`.

---
 rtl/noc_packetizer_if.sv | 15 +
 rtl/noc_packetizer.sv | 116 +++++++++++
 tb/tb_noc_packetizer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_packetizer_if.sv
// AXI-Stream style handshake bundle used on both sides of the packetizer.
// The source side drives tdest; the router side leaves it at zero.
interface noc_packetizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_W     = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_W-1:0]     tdest;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tdest, tlast, tvalid, input tready);
  modport slave  (input tdata, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/noc_packetizer.sv
// Store-and-forward NoC packet builder: buffers up to MAX_PAYLOAD source beats,
// then emits a header flit {cnt, src_y, src_x, dst_y, dst_x} followed by the beats.
module noc_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int MAX_PAYLOAD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  noc_packetizer_if.slave   s,
  noc_packetizer_if.master  m,
  output logic [15:0]       pkt_sent
);
  localparam int XW = $clog2(MAX_ROUTERS_X);
  localparam int YW = $clog2(MAX_ROUTERS_Y);
  localparam int DW = XW + YW;
  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [XW-1:0] SRC_X     = XW'(ROUTER_X);
  localparam logic [YW-1:0] SRC_Y     = YW'(ROUTER_Y);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_PAYLOAD - 1);

  typedef enum logic [1:0] {ST_FILL, ST_HEADER, ST_DRAIN} state_t;

  state_t                r_state, w_nstate;
  logic [DATA_WIDTH-1:0] r_buf [MAX_PAYLOAD];
  logic [AW-1:0]         r_wr, r_rd;
  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_dest;
  logic                  r_in_msg;
  logic                  r_live;
  logic [15:0]           r_pkt_sent;

  logic                  w_s_hs, w_m_hs, w_last;
  logic                  w_s_tready, w_m_tvalid, w_m_tlast;
  logic [DATA_WIDTH-1:0] w_hdr, w_m_tdata;

  assign w_hdr  = DATA_WIDTH'({r_cnt, SRC_Y, SRC_X, r_dest});
  assign w_last = (CW'(r_rd) == r_cnt - CW'(1));
  assign w_s_hs = w_s_tready & s.tvalid;
  assign w_m_hs = w_m_tvalid & m.tready;

  assign s.tready = w_s_tready;
  assign m.tvalid = w_m_tvalid;
  assign m.tlast  = w_m_tlast;
  assign m.tdata  = w_m_tdata;
  assign m.tdest  = '0;
  assign pkt_sent = r_pkt_sent;

  // r_live holds s_tready low until the first edge after reset release
  always_comb begin
    w_nstate   = r_state;
    w_s_tready = 1'b0;
    w_m_tvalid = 1'b0;
    w_m_tlast  = 1'b0;
    w_m_tdata  = '0;
    unique case (r_state)
      ST_FILL: begin
        w_s_tready = r_live;
        if (r_live && s.tvalid && (s.tlast || r_cnt == LAST_SLOT))
          w_nstate = ST_HEADER;
      end
      ST_HEADER: begin
        w_m_tvalid = 1'b1;
        w_m_tdata  = w_hdr;
        if (m.tready) w_nstate = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_m_tvalid = 1'b1;
        w_m_tdata  = r_buf[r_rd];
        w_m_tlast  = w_last;
        if (m.tready && w_last) w_nstate = ST_FILL;
      end
      default: w_nstate = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_cnt      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_dest     <= '0;
      r_in_msg   <= 1'b0;
      r_live     <= 1'b0;
      r_pkt_sent <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_nstate;
      if (w_s_hs) begin
        r_wr  <= r_wr + AW'(1);
        r_cnt <= r_cnt + CW'(1);
        if (!r_in_msg) r_dest <= s.tdest;
        // a split message keeps in_msg set so its later packets reuse r_dest
        r_in_msg <= !s.tlast;
      end
      if (r_state == ST_HEADER && w_m_hs) r_rd <= '0;
      if (r_state == ST_DRAIN && w_m_hs) begin
        r_rd <= r_rd + AW'(1);
        if (w_last) begin
          r_cnt      <= '0;
          r_wr       <= '0;
          r_pkt_sent <= r_pkt_sent + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_hs) r_buf[r_wr] <= s.tdata;
  end
endmodule

// File: tb/tb_noc_packetizer.sv
// Directed + table-driven bench for noc_packetizer (ROUTER_X=1, ROUTER_Y=2, MAX_PAYLOAD=4).
module tb_noc_packetizer;
  localparam int DW = 32;

  logic        clk, rst;
  logic [15:0] pkt_sent;

  noc_packetizer_if #(.DATA_WIDTH(DW), .DEST_W(4)) s_if ();
  noc_packetizer_if #(.DATA_WIDTH(DW), .DEST_W(4)) m_if ();

  noc_packetizer #(
    .DATA_WIDTH(DW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
    .ROUTER_X(1), .ROUTER_Y(2), .MAX_PAYLOAD(4)
  ) dut (
    .clk(clk), .rst(rst), .s(s_if), .m(m_if), .pkt_sent(pkt_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [3:0]  dest;
    logic [3:0]  dest2;
    logic [31:0] base;
    int          pkts;
    logic [31:0] hdr0;
    logic [31:0] hdr1;
  } vec_t;

  vec_t        vecs [5];
  int          n_chk = 0, n_err = 0, exp_ps = 0;
  logic [31:0] tx_q[$], rx_d[$], exp_d[$];
  bit          rx_l[$], exp_l[$];
  int          rx_c[$], s_c[$];
  int          r_len [100];
  logic [3:0]  r_dst [100];
  logic [15:0] wexp [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // header layout: [10:8] count, [7:6] src_y=2, [5:4] src_x=1, [3:0] {dst_y, dst_x}
  function automatic logic [31:0] hdr(input int c, input logic [3:0] d);
    return {21'd0, 3'(c), 2'd2, 2'd1, d};
  endfunction

  task automatic send(input int n, input logic [3:0] d, input logic [3:0] d2);
    bit ok;
    for (int i = 0; i < n; i++) begin
      ok          = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = tx_q.pop_front();
      s_if.tdest  = (i >= 4) ? d2 : d;
      s_if.tlast  = (i == n - 1);
      for (int t = 0; t < 2000 && !ok; t++) begin
        @(negedge clk);
        if (s_if.tready) begin
          ok = 1'b1;
          s_c.push_back(cyc);
        end
      end
      if (!ok) begin
        n_chk++; n_err++;
        $display("FAIL send_timeout: beat %0d got tready=0, expected tready=1", i);
        break;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic collect(input int npkt, input bit stall);
    int          got;
    bit          pend;
    logic [31:0] pd;
    logic        pl;
    got = 0; pend = 1'b0; pd = '0; pl = 1'b0;
    rx_d.delete(); rx_l.delete(); rx_c.delete();
    for (int t = 0; t < 20000 && got < npkt; t++) begin
      @(negedge clk);
      if (pend) begin
        chk("stall_valid", m_if.tvalid, 1);
        chk("stall_data", m_if.tdata, pd);
        chk("stall_last", m_if.tlast, pl);
      end
      pend = 1'b0;
      if (m_if.tvalid) begin
        if (m_if.tready) begin
          rx_d.push_back(m_if.tdata);
          rx_l.push_back(m_if.tlast);
          rx_c.push_back(cyc);
          if (m_if.tlast) got++;
        end else begin
          pend = 1'b1; pd = m_if.tdata; pl = m_if.tlast;
        end
      end
      @(posedge clk); #1;
      if (stall) m_if.tready = 1'($urandom_range(0, 1));
    end
    if (got < npkt) begin
      n_chk++; n_err++;
      $display("FAIL collect_timeout: got %0d packets, expected %0d", got, npkt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int k, len, total, pos, rem, c, npk;
    vecs[0] = '{1, 4'hB, 4'hB, 32'h0000_00A5, 1, 32'h19B, 32'h0};
    vecs[1] = '{4, 4'h4, 4'h4, 32'h0000_1000, 1, 32'h494, 32'h0};
    vecs[2] = '{6, 4'h5, 4'hA, 32'h0000_2000, 2, 32'h495, 32'h295};
    vecs[3] = '{3, 4'h9, 4'h9, 32'h0000_3000, 1, 32'h399, 32'h0};
    vecs[4] = '{5, 4'hF, 4'h0, 32'h0000_4000, 2, 32'h49F, 32'h19F};
    wexp[0] = 16'hFFFF; wexp[1] = 16'h0000; wexp[2] = 16'h0001;

    // reset with a valid source beat pending
    rst = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 32'hDEAD; s_if.tdest = 4'hB; s_if.tlast = 1'b1;
    m_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_s_tready", s_if.tready, 1);
    chk("post_rst_m_tvalid", m_if.tvalid, 0);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;

    for (int v = 0; v < 5; v++) begin
      tx_q.delete(); s_c.delete();
      for (int i = 0; i < vecs[v].n; i++) tx_q.push_back(vecs[v].base + 32'(i));
      fork
        send(vecs[v].n, vecs[v].dest, vecs[v].dest2);
        collect(vecs[v].pkts, 1'b0);
      join
      exp_ps += vecs[v].pkts;
      chk($sformatf("v%0d_pkt_sent", v), pkt_sent, exp_ps);
      total = vecs[v].n + vecs[v].pkts;
      chk($sformatf("v%0d_flits", v), rx_d.size(), total);
      if (rx_d.size() == total) begin
        k = 0;
        for (int p = 0; p < vecs[v].pkts; p++) begin
          chk($sformatf("v%0d_hdr%0d", v, p), rx_d[k], (p == 0) ? vecs[v].hdr0 : vecs[v].hdr1);
          chk($sformatf("v%0d_hdr%0d_last", v, p), rx_l[k], 0);
          k++;
          len = (p == 0) ? ((vecs[v].n < 4) ? vecs[v].n : 4) : vecs[v].n - 4;
          for (int j = 0; j < len; j++) begin
            chk($sformatf("v%0d_p%0d_d%0d", v, p, j), rx_d[k], vecs[v].base + 32'(4 * p + j));
            chk($sformatf("v%0d_p%0d_l%0d", v, p, j), rx_l[k], (j == len - 1));
            k++;
          end
        end
        if (vecs[v].n <= 4) begin
          chk($sformatf("v%0d_hdr_lat", v), rx_c[0] - s_c[vecs[v].n - 1], 1);
          chk($sformatf("v%0d_last_lat", v), rx_c[vecs[v].n] - s_c[vecs[v].n - 1], vecs[v].n + 1);
        end
      end
    end

    // 100 random messages with 50% router back-pressure
    tx_q.delete(); exp_d.delete(); exp_l.delete(); s_c.delete();
    npk = 0; pos = 0;
    for (int mi = 0; mi < 100; mi++) begin
      r_len[mi] = $urandom_range(1, 7);
      r_dst[mi] = 4'($urandom_range(0, 15));
      for (int i = 0; i < r_len[mi]; i++) tx_q.push_back($urandom);
    end
    for (int mi = 0; mi < 100; mi++) begin
      rem = r_len[mi];
      while (rem > 0) begin
        c = (rem > 4) ? 4 : rem;
        exp_d.push_back(hdr(c, r_dst[mi])); exp_l.push_back(1'b0);
        for (int j = 0; j < c; j++) begin
          exp_d.push_back(tx_q[pos]); exp_l.push_back(j == c - 1);
          pos++;
        end
        rem -= c; npk++;
      end
    end
    fork
      begin
        for (int mi = 0; mi < 100; mi++) begin
          send(r_len[mi], r_dst[mi], ~r_dst[mi]);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
      collect(npk, 1'b1);
    join
    m_if.tready = 1'b1;
    exp_ps += npk;
    chk("rnd_flits", rx_d.size(), exp_d.size());
    if (rx_d.size() == exp_d.size())
      for (int i = 0; i < exp_d.size(); i++) begin
        chk($sformatf("rnd_d%0d", i), rx_d[i], exp_d[i]);
        chk($sformatf("rnd_l%0d", i), rx_l[i], exp_l[i]);
      end
    chk("rnd_pkt_sent", pkt_sent, 32'(exp_ps & 32'hFFFF));

    // reset in the middle of a drain
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(32'h5000 + 32'(i));
    send(4, 4'h6, 4'h6);
    repeat (3) @(posedge clk);
    #2;
    chk("md_pre_valid", m_if.tvalid, 1);
    chk("md_pre_data", m_if.tdata, 32'h5002);
    rst = 1'b1;
    #1;
    chk("md_valid_drop", m_if.tvalid, 0);
    chk("md_s_tready", s_if.tready, 0);
    chk("md_pkt_sent", pkt_sent, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tx_q.push_back(32'h6000); tx_q.push_back(32'h6001);
    fork
      send(2, 4'h7, 4'h7);
      collect(1, 1'b0);
    join
    chk("md_flits", rx_d.size(), 3);
    if (rx_d.size() == 3) begin
      chk("md_hdr", rx_d[0], 32'h297);
      chk("md_d0", rx_d[1], 32'h6000);
      chk("md_d1", rx_d[2], 32'h6001);
      chk("md_l1", rx_l[2], 1);
    end
    chk("md_pkt_sent_after", pkt_sent, 1);

    // packet counter wrap, preset close to the top
    @(negedge clk);
    force dut.r_pkt_sent = 16'hFFFE;
    @(posedge clk); #1;
    release dut.r_pkt_sent;
    chk("wrap_preset", pkt_sent, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(32'h7000 + 32'(i));
      fork
        send(1, 4'h3, 4'h3);
        collect(1, 1'b0);
      join
      chk($sformatf("wrap_%0d", i), pkt_sent, wexp[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
